// File: rtl/ifu_fetch_pkg.sv
// Shared core definitions for the instruction fetch unit: FSM state encoding,
// the default reset PC and the {pc,instr} fetch-buffer entry.
package ifu_fetch_pkg;

   localparam logic [31:0] IFU_RESET_PC_DEFAULT = 32'h0000_0000;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t ST_BOOT  = 2'd0;
   localparam fetch_state_t ST_FETCH = 2'd1;
   localparam fetch_state_t ST_DRAIN = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Fetch buffer: a small power-of-two FIFO of {pc,instr} entries with a
// synchronous clear that drops every entry when the front end is redirected.
module ifu_fifo
   import ifu_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             clear,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   output fetch_entry_t     head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A push into a full buffer is legal when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues word fetches, buffers responses for decode and
// handles redirects by discarding in-flight responses. Optional macro
// IFU_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = IFU_RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_b,
   output logic        ibus_req,
   output logic [31:0] ibus_addr,
   input  logic        ibus_ready,
   input  logic        ibus_rvalid,
   input  logic [31:0] ibus_rdata,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        ifu_valid,
   input  logic        ifu_ready,
   output logic [31:0] ifu_instruction,
   output logic [31:0] ifu_pc
);

   localparam int             CNT_W     = $clog2(BUF_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(BUF_DEPTH);

   fetch_state_t     state;
   logic [31:0]      fetch_pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] outstanding_nxt;
   logic [CNT_W-1:0] discard_cnt;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   slots_used;
   logic             req_acc;
   logic             rsp_keep;
   logic             bypass_take;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic [31:0]      rsp_pc;
   fetch_entry_t     rsp_entry;
   fetch_entry_t     fifo_head;
   logic             unused_ok;

   assign unused_ok = ^{flush_pc[1:0], fifo_full};

   // Every in-flight request must have a buffer slot waiting for its response.
   assign slots_used = {1'b0, outstanding} + {1'b0, fifo_count};
   assign ibus_req   = (state == ST_FETCH) && (slots_used < DEPTH_LIM);
   assign ibus_addr  = fetch_pc;
   assign req_acc    = ibus_req & ibus_ready;

   assign outstanding_nxt = outstanding + CNT_W'(req_acc) - CNT_W'(ibus_rvalid);

   // Outside DRAIN all in-flight requests are consecutive words ending at
   // fetch_pc, so the oldest one's address follows from the outstanding count.
   assign rsp_pc    = fetch_pc - 32'({outstanding, 2'b00});
   assign rsp_keep  = ibus_rvalid && (state == ST_FETCH) && !flush;
   assign rsp_entry = '{pc: rsp_pc, instr: ibus_rdata};

`ifdef IFU_BYPASS_EN
   assign bypass_take = rsp_keep && fifo_empty && ifu_ready;
`else
   assign bypass_take = 1'b0;
`endif

   assign fifo_push = rsp_keep && !bypass_take;
   assign fifo_pop  = ifu_ready && !fifo_empty;

   assign ifu_valid       = !fifo_empty || bypass_take;
   assign ifu_instruction = bypass_take ? ibus_rdata : fifo_head.instr;
   assign ifu_pc          = bypass_take ? rsp_pc     : fifo_head.pc;

   ifu_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_b     (rst_b),
      .clear     (flush),
      .push      (fifo_push),
      .push_data (rsp_entry),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // A flush wins in every state; everything still in flight, including a
   // request accepted in the flush cycle itself, becomes discard work.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state       <= ST_BOOT;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard_cnt <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (flush) begin
            fetch_pc    <= {flush_pc[31:2], 2'b00};
            discard_cnt <= outstanding_nxt;
            state       <= (outstanding_nxt == '0) ? ST_FETCH : ST_DRAIN;
         end else begin
            case (state)
               ST_BOOT: begin
                  state <= ST_FETCH;
               end
               ST_FETCH: begin
                  if (req_acc) fetch_pc <= fetch_pc + 32'd4;
               end
               ST_DRAIN: begin
                  if (ibus_rvalid) begin
                     discard_cnt <= discard_cnt - CNT_W'(1);
                     if (discard_cnt == CNT_W'(1)) state <= ST_FETCH;
                  end
               end
               default: begin
                  state <= ST_BOOT;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: fetch-buffer entries, power of 2, range 2..8.
REQ-003 SHALL have clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have rst_b  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ibus_req  output  1  instruction-bus request valid.
REQ-006 SHALL have ibus_addr  output  32  word-aligned request address.
REQ-007 SHALL have ibus_ready  input  1  bus accepts the request this cycle.
REQ-008 SHALL have ibus_rvalid  input  1  read-data valid; in-order; no backpressure.
REQ-009 SHALL have ibus_rdata  input  32  returned instruction word.
REQ-010 SHALL have flush  input  1  redirect from a taken branch, jump or trap.
REQ-011 SHALL have flush_pc  input  32  redirect target, bits [1:0] ignored.
REQ-012 SHALL have ifu_valid  output  1  instruction/PC pair valid to the decode stage.
REQ-013 SHALL have ifu_ready  input  1  decode stage accepts this cycle.
REQ-014 SHALL have ifu_instruction  output  32  instruction word for decode.
REQ-015 SHALL have ifu_pc  output  32  address of ifu_instruction.

Function
REQ-016 SHALL treat a request as accepted when ibus_req & ibus_ready, and a transfer to decode as ifu_valid & ifu_ready.
REQ-017 SHALL issue a request only while outstanding + buffer_count < BUF_DEPTH, so every response has a guaranteed slot.
REQ-018 SHALL hold ibus_req and ibus_addr stable until acceptance, unless flush occurs.
REQ-019 SHALL advance fetch_pc by 4 on acceptance, with 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-020 SHALL write each non-discarded response into the buffer together with the address that requested it.
REQ-021 SHALL present the buffer head on ifu_* and hold it stable while ifu_valid & ~ifu_ready.
REQ-022 SHALL support a simultaneous buffer write and read when the buffer is full and ifu_ready=1.
REQ-023 SHALL implement the FSM BOOT -> FETCH -> DRAIN.
- BOOT: entered on reset; lasts one cycle with no request; goes to FETCH.
- FETCH: normal operation.
- DRAIN: entered on flush while unreturned requests exist; issues no requests; discards responses; goes to FETCH in the cycle the discard counter reaches 0.
REQ-024 SHALL, on flush in any state, empty the buffer and deassert ifu_valid in the next cycle.
REQ-025 SHALL, on flush, load fetch_pc = {flush_pc[31:2],2'b00} and copy outstanding into discard_cnt.
- If discard_cnt is 0, go straight to FETCH and request the new pc next cycle.
REQ-026 SHALL discard a response that arrives in the same cycle as flush, and count that response in the discard.
REQ-027 SHALL update pc and discard_cnt on a flush received during DRAIN, and stay in DRAIN.
REQ-028 SHALL ignore a request accepted in the flush cycle (ibus_req already high); its response is counted as discarded.

Reset
REQ-029 SHALL, on reset: fetch_pc=RESET_PC, state=BOOT, buffer empty, outstanding=0, discard_cnt=0, ibus_req=0, ibus_addr=RESET_PC, ifu_valid=0, ifu_instruction=0, ifu_pc=0.
REQ-030 SHALL abandon all in-flight transactions on reset assertion mid-operation; the bus side is reset in the same domain.

Configuration
REQ-031 SHALL honour the macro IFU_BYPASS_EN.
- Defined: a response arriving while the buffer is empty and ifu_ready=1 is presented the same cycle, combinationally from ibus_rdata (0-cycle latency).
- Undefined: every response is registered first; minimum latency rvalid -> ifu_valid is 1 cycle.

Structure
REQ-032 SHALL place the FSM state enum and the RESET_PC default in the shared core package.
REQ-033 SHALL implement the buffer as one sub-module ifu_fifo, holding {pc,instr}, with parameter depth and full/empty/count outputs.

Verification
REQ-034 SHALL cover reset release with ibus_ready=1 and 1-cycle response: first request addr=RESET_PC at cycle 2, then 0x4, 0x8; ifu_pc sequence 0,4,8.
REQ-035 SHALL cover ifu_ready=0 for 10 cycles: at most BUF_DEPTH requests outstanding or buffered, head held stable, no loss after release.
REQ-036 SHALL cover flush_pc=0x1002 with 2 outstanding requests: both responses dropped, DRAIN for 2 responses, next request addr=0x1000, ifu_pc=0x1000.
REQ-037 SHALL cover flush in the same cycle as rvalid plus a second flush during DRAIN to 0x2000: only 0x2000-path instructions reach decode.
REQ-038 SHALL cover fetch_pc=0xFFFF_FFFC: next request addr wraps to 0x0000_0000.
REQ-039 SHALL cover IFU_BYPASS_EN defined vs undefined with empty buffer and rvalid at cycle t: ifu_valid at t vs t+1.
